cpu_run_monitor: RTL

Hardware run-control stage wrapped around the CPU core; consumes the core's halt output and drives the core's reset.
- Holds the CPU in reset for a fixed number of cycles after system reset, then releases it.
- Counts run cycles until the CPU asserts halt, or until a timeout expires.
- Reports the outcome (halted / timed out) and the cycle count so that boards and benches can read a run result without a behavioural timeout loop.

---
 rtl/run_mon_pkg.sv | 13 +
 rtl/run_mon_counter.sv | 21 ++
 rtl/cpu_run_monitor.sv | 99 +++++++++
 3 files changed

// File: rtl/run_mon_pkg.sv
// Shared definitions for the CPU run monitor: the 2-bit run state encoding.
package run_mon_pkg;

  localparam int STATE_W = 2;

  typedef logic [STATE_W-1:0] state_t;

  localparam logic [1:0] HOLD    = 2'd0;
  localparam logic [1:0] RUN     = 2'd1;
  localparam logic [1:0] HALTED  = 2'd2;
  localparam logic [1:0] TIMEOUT = 2'd3;

endpackage

// File: rtl/run_mon_counter.sv
// Up-counter with synchronous clear and optional saturation at all-ones.
module run_mon_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         enable,
  input  logic         saturate,
  output logic [W-1:0] count
);

  // Clear dominates; when saturating, the all-ones value is sticky.
  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (enable && !(saturate && (count == {W{1'b1}}))) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/cpu_run_monitor.sv
// Run-control wrapper for the CPU core: reset hold, run/halt/timeout tracking.
// Define RUN_MON_INSTR_COUNT_EN to add the instr_retired input and instr_count output.
module cpu_run_monitor
  import run_mon_pkg::*;
#(
  parameter int RESET_HOLD_CYCLES = 5,
  parameter int TIMEOUT_CYCLES    = 2000,
  parameter int CNT_W             = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             cpu_halt,
`ifdef RUN_MON_INSTR_COUNT_EN
  input  logic             instr_retired,
  output logic [CNT_W-1:0] instr_count,
`endif
  output logic             cpu_reset,
  output logic             running,
  output logic             done,
  output logic             timed_out,
  output logic [CNT_W-1:0] cycle_count,
  output state_t           state
);

  localparam int HOLD_W = (RESET_HOLD_CYCLES > 1) ? $clog2(RESET_HOLD_CYCLES) : 1;

  logic [HOLD_W-1:0] hold_count;
  state_t            next_state;
  logic              start_accept;
  logic              hold_last;
  logic              at_limit;
  logic              counters_clear;

  assign start_accept   = start && ((state == HALTED) || (state == TIMEOUT));
  assign hold_last      = (hold_count == HOLD_W'(RESET_HOLD_CYCLES - 1));
  assign at_limit       = (cycle_count == CNT_W'(TIMEOUT_CYCLES - 1));
  assign counters_clear = reset || start_accept;

  // Halt is checked before the timeout limit so a halt on the last cycle wins.
  always_comb begin
    next_state = state;
    case (state)
      HOLD:    if (hold_last) next_state = RUN;
      RUN: begin
        if (cpu_halt)      next_state = HALTED;
        else if (at_limit) next_state = TIMEOUT;
      end
      HALTED:  if (start) next_state = HOLD;
      TIMEOUT: if (start) next_state = HOLD;
      default: next_state = HOLD;
    endcase
  end

  // Status outputs are registered from next_state so they line up with state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= HOLD;
      cpu_reset <= 1'b1;
      running   <= 1'b0;
      done      <= 1'b0;
      timed_out <= 1'b0;
    end else begin
      state     <= next_state;
      cpu_reset <= (next_state == HOLD) || (next_state == TIMEOUT);
      running   <= (next_state == RUN);
      done      <= (next_state == HALTED) || (next_state == TIMEOUT);
      timed_out <= (next_state == TIMEOUT);
    end
  end

  run_mon_counter #(.W(HOLD_W)) u_hold_counter (
    .clk      (clk),
    .clear    (counters_clear),
    .enable   ((state == HOLD) && !hold_last),
    .saturate (1'b0),
    .count    (hold_count)
  );

  // Bounded by TIMEOUT_CYCLES, so no saturation is needed here.
  run_mon_counter #(.W(CNT_W)) u_cycle_counter (
    .clk      (clk),
    .clear    (counters_clear),
    .enable   ((state == RUN) && !cpu_halt),
    .saturate (1'b0),
    .count    (cycle_count)
  );

`ifdef RUN_MON_INSTR_COUNT_EN
  run_mon_counter #(.W(CNT_W)) u_instr_counter (
    .clk      (clk),
    .clear    (counters_clear),
    .enable   ((state == RUN) && instr_retired),
    .saturate (1'b1),
    .count    (instr_count)
  );
`endif

endmodule
